// File: rtl/rtc_bus_sequencer_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC bus sequencer.
//   mode_e       : latched access type (NONE = read refresh / idle, others are writes)
//   A_D..WR_N    : bit positions inside the 4-bit control word
//   PH_*         : frame phase boundaries of the strobe sequence
//   IDLE_WORD    : all strobes inactive
//   READ_REFRESH : set by macro RTC_READ_REFRESH_EN (NONE frames run the read decode)
package rtc_bus_pkg;
    typedef enum logic [1:0] {NONE, TIME, DATE, TIMER} mode_e;
    localparam int A_D  = 3;
    localparam int CS_N = 2;
    localparam int RD_N = 1;
    localparam int WR_N = 0;
    localparam logic [5:0] PH_ADDR     = 6'd2;
    localparam logic [5:0] PH_ASTB     = 6'd3;
    localparam logic [5:0] PH_ASTB_END = 6'd7;
    localparam logic [5:0] PH_GAP      = 6'd10;
    localparam logic [5:0] PH_DATA     = 6'd12;
    localparam logic [5:0] PH_DSTB     = 6'd13;
    localparam logic [5:0] PH_DSTB_END = 6'd17;
    localparam logic [5:0] PH_END      = 6'd20;
    localparam logic [3:0] IDLE_WORD   = 4'b1111;
`ifdef RTC_READ_REFRESH_EN
    localparam bit READ_REFRESH = 1'b1;
`else
    localparam bit READ_REFRESH = 1'b0;
`endif
endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// rtc_bus_sequencer_if: mode requests in, bus strobes and frame phase out.
//   stime/date/timer : write requests from the mode controller
//   control          : {a_d, cs_n, rd_n, wr_n} towards the RTC pin drivers
//   counter          : frame phase for the data-path byte selection
//   master = mode controller side, slave = sequencer side
interface rtc_bus_sequencer_if;
    logic       stime;
    logic       date;
    logic       timer;
    logic [3:0] control;
    logic [5:0] counter;
    modport master (output stime, date, timer, input control, counter);
    modport slave  (input stime, date, timer, output control, counter);
endinterface

// File: rtl/rtc_bus_sequencer_phase_decode.sv
// rtc_bus_phase_decode: combinational (phase, mode) -> strobe word.
//   counter_i : frame phase
//   mode_i    : access type of the current frame
//   control_o : {a_d, cs_n, rd_n, wr_n}
module rtc_bus_phase_decode
    import rtc_bus_pkg::*;
(
    input  logic [5:0] counter_i,
    input  mode_e      mode_i,
    output logic [3:0] control_o
);
    logic wr_mode, active, addr_ph, data_ph, addr_stb, data_stb;
    always_comb begin
        wr_mode   = mode_i != NONE;
        active    = wr_mode || READ_REFRESH;
        addr_ph   = counter_i >= PH_ADDR && counter_i < PH_GAP;
        data_ph   = counter_i >= PH_DATA && counter_i < PH_END;
        addr_stb  = counter_i >= PH_ASTB && counter_i <= PH_ASTB_END;
        data_stb  = counter_i >= PH_DSTB && counter_i <= PH_DSTB_END;
        control_o = IDLE_WORD;
        control_o[A_D]  = ~(active & addr_ph);
        control_o[CS_N] = ~(active & (addr_ph | data_ph));
        // the address strobe is always wr_n; only the data strobe selects rd_n vs wr_n
        control_o[RD_N] = ~(active & ~wr_mode & data_stb);
        control_o[WR_N] = ~(active & (addr_stb | (wr_mode & data_stb)));
    end
endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: frame counter, per-frame mode latch and registered strobes.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : rtc_bus_sequencer_if.slave (stime/date/timer in, control/counter out)
//   CYCLE_LEN : frame length in clocks (21..64)
//   Macro RTC_READ_REFRESH_EN: NONE frames perform the read decode instead of idling.
module rtc_bus_sequencer
    import rtc_bus_pkg::*;
#(
    parameter int CYCLE_LEN = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    rtc_bus_sequencer_if.slave    bus
);
    logic [5:0] counter_q, counter_d;
    logic [3:0] control_q, control_d;
    mode_e      mode_q, mode_d;
    logic       wrap;
    always_comb begin
        wrap      = counter_q == 6'(CYCLE_LEN - 1);
        counter_d = wrap ? '0 : counter_q + 6'd1;
        mode_d    = !wrap     ? mode_q :
                    bus.stime ? TIME   :
                    bus.date  ? DATE   :
                    bus.timer ? TIMER  : NONE;
    end
    // decoding the next state keeps control aligned with counter after the register
    rtc_bus_phase_decode u_decode (
        .counter_i (counter_d),
        .mode_i    (mode_d),
        .control_o (control_d)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q <= '0;
            mode_q    <= NONE;
            control_q <= IDLE_WORD;
        end else begin
            counter_q <= counter_d;
            mode_q    <= mode_d;
            control_q <= control_d;
        end
    end
    assign bus.control = control_q;
    assign bus.counter = counter_q;
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: self-checking bench for rtc_bus_sequencer.
module tb_rtc_bus_sequencer;
    localparam int LEN = 40;
`ifdef RTC_READ_REFRESH_EN
    localparam bit REF = 1'b1;
`else
    localparam bit REF = 1'b0;
`endif
    localparam logic [3:0] NONE5  = REF ? 4'b0010 : 4'b1111;
    localparam logic [3:0] NONE15 = REF ? 4'b1001 : 4'b1111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus ();
    rtc_bus_sequencer #(.CYCLE_LEN(LEN)) dut (.clk(clk), .reset(rst_n), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int m_cnt, m_mode;
    logic [3:0] prev_ctrl;
    logic prev_valid = 1'b0;

    typedef struct {
        logic s, d, t;
        logic [3:0] exp5, exp15;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [3:0] ref_ctrl(int c, int m);
        if (m == 0 && !REF) return 4'b1111;
        if (c < 2) return 4'b1111;
        if (c == 2) return 4'b0011;
        if (c <= 7) return 4'b0010;
        if (c <= 9) return 4'b0011;
        if (c <= 11) return 4'b1111;
        if (c == 12) return 4'b1011;
        if (c <= 17) return (m == 0) ? 4'b1001 : 4'b1010;
        if (c <= 19) return 4'b1011;
        return 4'b1111;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cnt(int v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.counter != 6'(v) && k < 200);
        chk("wait_counter", 8'(bus.counter), 8'(v));
    endtask

    // reference: frame counter with mode sampled by priority at each wrap
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_mode <= 0;
        end else if (m_cnt == LEN - 1) begin
            m_cnt  <= 0;
            m_mode <= bus.stime ? 1 : bus.date ? 2 : bus.timer ? 3 : 0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        chk("counter", 8'(bus.counter), 8'(m_cnt));
        chk("control", 8'(bus.control), 8'(ref_ctrl(m_cnt, m_mode)));
        chk("inv_rd_wr", 8'(bus.control[1] | bus.control[0]), 8'd1);
        chk("inv_strobe_cs", 8'(!bus.control[2] || (bus.control[1] && bus.control[0])), 8'd1);
        if (prev_valid)
            chk("inv_ad", 8'((prev_ctrl[3] == bus.control[3]) || prev_ctrl[2] || bus.control[2]), 8'd1);
        prev_ctrl  <= bus.control;
        prev_valid <= rst_n;
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, NONE5, NONE15};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0010, 4'b1010};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 4'b0010, 4'b1010};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 4'b0010, 4'b1010};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'b0010, 4'b1010};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 4'b0010, 4'b1010};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 4'b0010, 4'b1010};
        tbl[7] = '{1'b0, 1'b0, 1'b0, NONE5, NONE15};
        bus.stime = 1'b0;
        bus.date  = 1'b0;
        bus.timer = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_counter", 8'(bus.counter), 8'd0);
        chk("reset_control", 8'(bus.control), 8'hf);
        #1 rst_n = 1'b1;
        bus.stime = 1'b1;
        wait_cnt(15);
        chk("first_frame_none", 8'(bus.control), 8'(NONE15));
        wait_cnt(5);
        chk("time_addr_strobe", 8'(bus.control), 8'b0010);
        wait_cnt(15);
        chk("time_data_strobe", 8'(bus.control), 8'b1010);
        wait_cnt(25);
        chk("time_tail_idle", 8'(bus.control), 8'hf);
        wait_cnt(39);
        @(negedge clk);
        chk("wrap_to_zero", 8'(bus.counter), 8'd0);
        bus.date = 1'b1;
        wait_cnt(5);
        bus.stime = 1'b0;
        wait_cnt(15);
        chk("time_frame_kept", 8'(bus.control), 8'b1010);
        wait_cnt(15);
        chk("date_frame", 8'(bus.control), 8'b1010);
        for (int i = 0; i < 8; i++) begin
            wait_cnt(30);
            bus.stime = tbl[i].s;
            bus.date  = tbl[i].d;
            bus.timer = tbl[i].t;
            wait_cnt(5);
            chk($sformatf("vec%0d_c5", i), 8'(bus.control), 8'(tbl[i].exp5));
            bus.stime = 1'($urandom);
            bus.date  = 1'($urandom);
            bus.timer = 1'($urandom);
            wait_cnt(15);
            chk($sformatf("vec%0d_c15", i), 8'(bus.control), 8'(tbl[i].exp15));
        end
        bus.stime = 1'b1;
        wait_cnt(15);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_counter", 8'(bus.counter), 8'd0);
        chk("async_reset_control", 8'(bus.control), 8'hf);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_counter", 8'(bus.counter), 8'd1);
        wait_cnt(15);
        chk("after_reset_none", 8'(bus.control), 8'(NONE15));
        repeat (30 * LEN) begin
            @(negedge clk);
            #1;
            bus.stime = $urandom_range(0, 5) == 0;
            bus.date  = $urandom_range(0, 4) == 0;
            bus.timer = $urandom_range(0, 3) == 0;
        end
`ifndef RTC_READ_REFRESH_EN
        bus.stime = 1'b0;
        bus.date  = 1'b0;
        bus.timer = 1'b0;
        wait_cnt(39);
        for (int i = 0; i < 2 * LEN; i++) begin
            @(negedge clk);
            chk("no_refresh_idle", 8'(bus.control), 8'hf);
            chk("no_refresh_count", 8'(bus.counter), 8'(i % LEN));
        end
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Generates the parallel-bus strobe sequence for the RTC chip: an address phase followed by a data phase, repeated every CYCLE_LEN clocks.
- Three mode requests choose the access type: set time, set date or set timer are writes; with no request it is a read refresh or idle.
- Sits between the top-level mode controller and the RTC pin drivers.
- Exposes its frame phase counter so the data-path block can select address and data bytes.

Parameters:
CYCLE_LEN, 40, frame length in clocks; legal range 21..64; counter runs 0..CYCLE_LEN-1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stime  input  1  request: write time registers.
date  input  1  request: write date registers.
timer  input  1  request: write timer registers.
control  output  4  bus strobes {a_d, cs_n, rd_n, wr_n}: [3]=a_d (0 = address phase), [2]=cs_n, [1]=rd_n, [0]=wr_n. All active-low except a_d.
counter  output  6  current frame phase.

Behaviour:
- Reset (reset=0, asynchronous): counter=0, control=4'b1111, latched mode=NONE. Outputs hold these values while reset is low.
- Counter: +1 every clk; CYCLE_LEN-1 wraps to 0. Free-running and never stalls.
- Mode latch: on the edge where counter goes CYCLE_LEN-1 -> 0, mode is sampled with priority stime > date > timer, else NONE.
  - Mode is constant for the whole frame. Input changes mid-frame have no effect until the next frame.
  - The first frame after reset always runs with mode NONE.
- control is registered and always equals decode(counter, mode) for the same cycle, so there is zero skew between the two outputs.
- Decode for write modes (TIME, DATE, TIMER):
  - counter 0-1: 1111.
  - 2: 0011 (a_d=0, cs_n=0).
  - 3-7: 0010 (wr_n=0, address strobe).
  - 8-9: 0011.
  - 10-11: 1111.
  - 12: 1011.
  - 13-17: 1010 (wr_n=0, data strobe).
  - 18-19: 1011.
  - 20..CYCLE_LEN-1: 1111.
- Decode for read mode (NONE, when refresh is enabled): identical except counter 13-17 gives 1001 (rd_n=0 instead of wr_n).
- Invariants:
  - rd_n and wr_n are never 0 in the same cycle.
  - A strobe is only ever low while cs_n=0.
  - a_d changes only while cs_n=1, at counter 2 and 10.
- Reset mid-frame: immediate return to the reset values; the sequence restarts at counter 0 with mode NONE.
- Simultaneous requests resolve by the priority above; only the winner's frame is run.

Optional Feature:
- Macro: RTC_READ_REFRESH_EN.
- Defined: a frame with mode NONE performs the read decode above.
- Undefined: a frame with mode NONE holds control=1111 for the whole frame; the counter still runs.
- Write-mode behaviour is identical in both builds.

Decomposition:
- Package rtc_bus_pkg holds:
  - mode enum NONE/TIME/DATE/TIMER;
  - control bit indices A_D=3, CS_N=2, RD_N=1, WR_N=0;
  - phase boundary constants 2, 3, 7, 10, 12, 13, 17, 20;
  - the idle word 4'b1111.
- One combinational sub-module, rtc_bus_phase_decode: (counter, mode) -> control. The top holds the counter, the mode latch and the output register.

Test Plan:
- Hold reset=0 for several clocks, then release -> counter=0, control=1111; first frame (mode NONE, refresh on) shows 1001 at counter 13-17.
- stime=1 from release -> from the second frame: counter 3-7 gives 0010, 13-17 gives 1010, 20-39 gives 1111; counter wraps 39 -> 0.
- stime=1 and date=1 together -> TIME frame is run; drop stime mid-frame -> current frame unchanged, next frame is the DATE write.
- Pulse reset=0 at counter=15 between clock edges -> control=1111 and counter=0 immediately; then restart from 0.
- Build without RTC_READ_REFRESH_EN, all requests 0 -> control stays 1111 for two full frames while counter cycles 0..39.
- Every cycle, every test: check the invariants (rd_n and wr_n never both 0; no strobe low while cs_n=1; a_d changes only while cs_n=1).
